// File: rtl/rf_write_arbiter.sv
// Two-requester write-port arbiter in front of a single-write-port register file.
// Grants are combinational; the register-file write is issued from registers one cycle later.
module rf_write_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [4:0]  req0_reg,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_reg,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        rf_regWrite,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  output logic [7:0]  stall_count
);

  logic        gnt0_s;
  logic        gnt1_s;
  logic        xfer_s;
  logic        deny_s;
  logic [4:0]  sel_reg_s;
  logic [31:0] sel_data_s;

  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic [4:0]  reg_q, reg_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  stall_q, stall_d;

  // Grant selection; ready is held low while reset is asserted
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      if (PRIO_MODE == 1) begin
        gnt1_s = 1'b1;
      end else if (last_grant_q) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
    end else if (req0_valid) begin
      gnt0_s = 1'b1;
    end else if (req1_valid) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Next-state for the write stage, round-robin pointer and stall counter
  always_comb begin
    xfer_s       = gnt0_s | gnt1_s;
    deny_s       = (req0_valid & ~gnt0_s) | (req1_valid & ~gnt1_s);
    sel_reg_s    = gnt1_s ? req1_reg : req0_reg;
    sel_data_s   = gnt1_s ? req1_data : req0_data;
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    reg_d        = reg_q;
    data_d       = data_q;
    stall_d      = stall_q;
    if (xfer_s) begin
      last_grant_d = gnt1_s;
      // Writes to x0 are accepted but swallowed; the index/data outputs keep their last values
      if (sel_reg_s != 5'd0) begin
        we_d   = 1'b1;
        reg_d  = sel_reg_s;
        data_d = sel_data_s;
      end else begin
        we_d   = 1'b0;
      end
    end else begin
      last_grant_d = last_grant_q;
    end
    if (deny_s && (stall_q != 8'hFF)) begin
      stall_d = stall_q + 8'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      reg_q        <= 5'd0;
      data_q       <= 32'd0;
      stall_q      <= 8'd0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      reg_q        <= reg_d;
      data_q       <= data_d;
      stall_q      <= stall_d;
    end
  end

  assign req0_ready    = gnt0_s;
  assign req1_ready    = gnt1_s;
  assign rf_regWrite   = we_q;
  assign rf_write_reg  = reg_q;
  assign rf_write_data = data_q;
  assign stall_count   = stall_q;

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: PRIO_MODE, default 0, selects arbitration: 0 = round-robin, 1 = fixed priority with req1 always winning.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low; the block is in reset while rst = 0.
REQ-004 req0_valid  input  1  requester 0 (execute writeback) has a write pending.
REQ-005 req0_reg  input  5  requester 0 destination register index.
REQ-006 req0_data  input  32  requester 0 write data.
REQ-007 req0_ready  output  1  requester 0 write accepted this cycle; combinational.
REQ-008 req1_valid, req1_reg, req1_data, req1_ready shall be the same as REQ-004..007, for requester 1 (load/memory writeback).
REQ-009 rf_regWrite  output  1  write enable to the register file; registered.
REQ-010 rf_write_reg  output  5  register file write index; registered.
REQ-011 rf_write_data  output  32  register file write data; registered.
REQ-012 stall_count  output  8  saturating count of denied-request cycles; registered.

Function
REQ-013 Handshake: a transfer occurs on a rising edge where reqN_valid = 1 and reqN_ready = 1; the requester holds reg/data stable while valid = 1 and ready = 0.
REQ-014 At most one requester is granted per cycle; a ready signal is never asserted while its valid is 0.
REQ-015 Single valid request: that requester is granted in the same cycle, regardless of PRIO_MODE.
REQ-016 Both valid, PRIO_MODE = 0: grant the requester that is not last_grant; last_grant is an internal 1-bit state.
REQ-017 Both valid, PRIO_MODE = 1: grant req1.
REQ-018 last_grant updates to the granted index on every transfer and holds when there is no transfer.
REQ-019 Latency: a transfer at edge N drives rf_regWrite = 1 with the granted reg/data during cycle N..N+1. The register file commits the write at edge N+1.
REQ-020 rf_regWrite deasserts after one cycle unless another transfer occurs; back-to-back transfers give continuous rf_regWrite = 1.
REQ-021 When rf_regWrite = 0, rf_write_reg and rf_write_data hold their last values.
REQ-022 Register x0: a request with reg = 0 is accepted normally and updates last_grant, but produces rf_regWrite = 0 on the following cycle.
REQ-023 Both requesters targeting the same register in the same cycle follow normal arbitration. The loser is written one or more cycles later, so the loser's data is the final value.
REQ-024 stall_count increments by 1 on each edge where a valid requester is not granted (max +1 per cycle) and saturates at 255 with no wrap.
REQ-025 No internal data buffering; the arbiter never drops an accepted write except the x0 case in REQ-022.

Reset
REQ-026 While rst = 0, outputs shall be forced immediately (asynchronously): rf_regWrite = 0, rf_write_reg = 0, rf_write_data = 0, stall_count = 0, last_grant = 1 (so req0 wins the first contention), and req0_ready = req1_ready = 0.
REQ-027 Reset asserted mid-operation discards any write issued the same cycle; no rf_regWrite pulse shall follow reset release without a new transfer.
REQ-028 Operation resumes on the first rising edge after rst returns to 1.

Verification
REQ-029 Single requester: req0 valid, reg 5, data 0xDEADBEEF -> req0_ready = 1 same cycle; next cycle rf_regWrite = 1, reg 5, data 0xDEADBEEF; the cycle after, rf_regWrite = 0.
REQ-030 Round-robin contention (PRIO_MODE = 0): both valid for 4 cycles after reset -> grants alternate 0,1,0,1; stall_count = 4.
REQ-031 Fixed priority (PRIO_MODE = 1): both valid for 3 cycles -> req1 granted each cycle, req0_ready = 0; stall_count = 3; req0 is granted when req1 drops.
REQ-032 x0 request: req1 valid, reg 0, data 0x1234 -> req1_ready = 1; next cycle rf_regWrite = 0; next contention is granted to req0.
REQ-033 Saturation: hold one requester starved for 300 cycles -> stall_count = 255 and stays 255.
REQ-034 Reset mid-stream: back-to-back grants, rst = 0 between edges -> rf_regWrite = 0 and stall_count = 0 immediately. After release with no valid inputs, rf_regWrite stays 0.
